// File: rtl/fetch_queue_if.sv
// Fetch-side bus bundle: redirect input from execute, the instruction
// memory request/response pair, and the decode valid/ready handshake.
interface fetch_queue_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_en;
    logic [29:0] mem_addr;
    logic [31:0] mem_data;
    logic        insn_valid;
    logic        insn_ready;
    logic [31:0] insn;
    logic [31:0] insn_pc;

    // Fetch unit side.
    modport master (
        input  redirect_valid, redirect_pc, mem_data, insn_ready,
        output mem_en, mem_addr, insn_valid, insn, insn_pc
    );

    // Environment side (execute, instruction memory, decode).
    modport slave (
        output redirect_valid, redirect_pc, mem_data, insn_ready,
        input  mem_en, mem_addr, insn_valid, insn, insn_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues word reads to a one-cycle-latency
// instruction memory, buffers returned words with their PCs in a DEPTH-entry
// circular FIFO, and hands them to decode over valid/ready. A redirect from
// execute flushes everything buffered and in flight.
module fetch_queue #(
    parameter logic [31:0] ENTRYPOINT = 32'h54,
    parameter int          DEPTH      = 4
) (
    input logic         clk,
    input logic         rst,
    fetch_queue_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   pc;
    logic [CW-1:0] count;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   fifo_insn [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];

    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   credit;

    // Handshake, credit-based issue decision and head read-out.
    always_comb begin
        // Occupancy after this cycle's pop, counting the word already in
        // flight; issuing only below DEPTH guarantees a slot for every return.
        credit = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(pop);

        bus.insn_valid = !rst && (count != '0) && !bus.redirect_valid;
        pop            = bus.insn_valid && bus.insn_ready;
        push           = inflight && !bus.redirect_valid;
        issue          = !rst && !bus.redirect_valid && (credit < DEPTH_C);

        bus.mem_en   = issue;
        bus.mem_addr = rst ? ENTRYPOINT[31:2] : pc[31:2];
        // No bypass: a returned word is only visible once it sits in the FIFO.
        bus.insn     = rst ? 32'h0 : fifo_insn[rd_ptr];
        bus.insn_pc  = rst ? 32'h0 : fifo_pc[rd_ptr];
    end

    // Fetch PC, in-flight tracking, FIFO pointers/occupancy and storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= ENTRYPOINT;
            count       <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_insn[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else begin
            if (push) begin
                fifo_insn[wr_ptr] <= bus.mem_data;
                fifo_pc[wr_ptr]   <= inflight_pc;
            end
            if (bus.redirect_valid) begin
                // Flush: buffered entries, the returning word and the request
                // in flight are all dropped; fetch restarts at the target.
                pc       <= {bus.redirect_pc[31:2], 2'b00};
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                inflight <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count    <= count + CW'(push) - CW'(pop);
                inflight <= issue;
                if (issue) begin
                    inflight_pc <= pc;
                    pc          <= pc + 32'd4;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed timing scenarios followed by
// randomized redirect/reset/back-pressure traffic against a stream model.
module tb_fetch_queue;
    localparam logic [31:0] ENTRY = 32'h54;
    localparam int          DEPTH = 4;

    logic clk;
    logic rst;
    fetch_queue_if bus();

    fetch_queue #(.ENTRYPOINT(ENTRY), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    logic [31:0] key = 32'h0;

    // Reference model state: the in-order stream of PCs decode must see,
    // the next address fetch must request, and words fetched but not consumed.
    logic [31:0] sb_q[$];
    logic [31:0] sb_tail;
    logic [31:0] fetch_next;
    int          outstanding;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ key;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flush(input logic [31:0] target);
        sb_q.delete();
        for (int i = 0; i < 8; i++) sb_q.push_back(target + 32'(4 * i));
        sb_tail     = target + 32'd28;
        fetch_next  = target;
        outstanding = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        @(negedge clk);
    endtask

    // Synchronous instruction memory: data for a request appears next cycle.
    initial begin
        logic        req;
        logic [31:0] ra;
        forever begin
            @(negedge clk);
            req = bus.mem_en;
            ra  = {bus.mem_addr, 2'b00};
            @(posedge clk);
            #1;
            bus.mem_data = req ? word_of(ra) : 32'hDEAD_BEEF;
        end
    end

    // Monitor: flush on reset/redirect, check fetch addresses, pop scoreboard.
    initial begin
        logic        hold_prev;
        logic [31:0] prev_pc;
        logic [31:0] prev_insn;
        logic [31:0] exp_pc;
        hold_prev = 1'b0;
        prev_pc   = '0;
        prev_insn = '0;
        flush(ENTRY);
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_mem_en", 32'(bus.mem_en), 0);
                check("rst_valid", 32'(bus.insn_valid), 0);
                check("rst_insn", bus.insn, 0);
                check("rst_insn_pc", bus.insn_pc, 0);
                check("rst_mem_addr", 32'(bus.mem_addr), 32'(ENTRY[31:2]));
                flush(ENTRY);
            end else if (bus.redirect_valid) begin
                check("redir_mem_en", 32'(bus.mem_en), 0);
                check("redir_valid", 32'(bus.insn_valid), 0);
                flush({bus.redirect_pc[31:2], 2'b00});
            end else begin
                if (hold_prev) begin
                    check("hold_valid", 32'(bus.insn_valid), 1);
                    check("hold_pc", bus.insn_pc, prev_pc);
                    check("hold_insn", bus.insn, prev_insn);
                end
                if (bus.mem_en) begin
                    check("fetch_addr", 32'(bus.mem_addr), 32'(fetch_next[31:2]));
                    fetch_next  = fetch_next + 32'd4;
                    outstanding++;
                end
                if (bus.insn_valid && bus.insn_ready) begin
                    exp_pc = sb_q.pop_front();
                    check("sb_pc", bus.insn_pc, exp_pc);
                    check("sb_insn", bus.insn, word_of(exp_pc));
                    outstanding--;
                    pops++;
                    while (sb_q.size() < 4) begin
                        sb_tail = sb_tail + 32'd4;
                        sb_q.push_back(sb_tail);
                    end
                end
                check("fetch_ahead_le_depth", 32'(outstanding <= DEPTH), 1);
            end
            hold_prev = !rst && !bus.redirect_valid && bus.insn_valid && !bus.insn_ready;
            prev_pc   = bus.insn_pc;
            prev_insn = bus.insn;
        end
    end

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        int r;
        int pops_start;
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.insn_ready     = 1'b1;
        bus.mem_data       = '0;

        next_cycle();
        next_cycle();
        rst = 1'b0;
        peek();
        check("c0_mem_en", 32'(bus.mem_en), 1);
        check("c0_addr", 32'(bus.mem_addr), 32'h15);
        check("c0_valid", 32'(bus.insn_valid), 0);
        next_cycle(); peek();
        check("c1_valid", 32'(bus.insn_valid), 0);
        next_cycle(); peek();
        check("c2_valid", 32'(bus.insn_valid), 1);
        check("c2_pc", bus.insn_pc, 32'h54);
        check("c2_insn", bus.insn, 32'h54);
        repeat (5) begin
            next_cycle(); peek();
            check("stream_valid", 32'(bus.insn_valid), 1);
        end

        // Back-pressure until full, then release.
        next_cycle();
        bus.insn_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            peek();
            if (i >= 4) begin
                check("stall_mem_en", 32'(bus.mem_en), 0);
                check("stall_valid", 32'(bus.insn_valid), 1);
            end
            next_cycle();
        end
        bus.insn_ready = 1'b1;
        peek();
        check("release_mem_en", 32'(bus.mem_en), 1);
        repeat (6) begin next_cycle(); peek(); end

        // Redirect with three buffered entries and one word in flight.
        next_cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h1002;
        peek();
        check("rT_valid", 32'(bus.insn_valid), 0);
        next_cycle();
        bus.redirect_valid = 1'b0;
        peek();
        check("rT1_mem_en", 32'(bus.mem_en), 1);
        check("rT1_addr", 32'(bus.mem_addr), 32'h400);
        check("rT1_valid", 32'(bus.insn_valid), 0);
        next_cycle(); peek();
        check("rT2_valid", 32'(bus.insn_valid), 0);
        next_cycle(); peek();
        check("rT3_valid", 32'(bus.insn_valid), 1);
        check("rT3_pc", bus.insn_pc, 32'h1000);
        repeat (4) begin next_cycle(); peek(); end

        // Back-to-back redirects: the second wins.
        next_cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        peek();
        next_cycle();
        bus.redirect_pc = 32'h300;
        peek();
        check("b2b_mem_en", 32'(bus.mem_en), 0);
        next_cycle();
        bus.redirect_valid = 1'b0;
        peek();
        check("b2b_addr", 32'(bus.mem_addr), 32'hC0);
        next_cycle(); peek();
        check("b2b_T2_valid", 32'(bus.insn_valid), 0);
        next_cycle(); peek();
        check("b2b_T3_valid", 32'(bus.insn_valid), 1);
        check("b2b_T3_pc", bus.insn_pc, 32'h300);

        // Redirect near the top of the address space; low bits ignored.
        next_cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFE;
        next_cycle();
        bus.redirect_valid = 1'b0;
        next_cycle();
        next_cycle(); peek();
        check("wrap_pc0", bus.insn_pc, 32'hFFFF_FFFC);
        next_cycle(); peek();
        check("wrap_valid1", 32'(bus.insn_valid), 1);
        check("wrap_pc1", bus.insn_pc, 32'h0);

        // Reset while the FIFO is full.
        next_cycle();
        bus.insn_ready = 1'b0;
        repeat (6) next_cycle();
        rst            = 1'b1;
        bus.insn_ready = 1'b1;
        key            = 32'hC0DE_0000;
        peek();
        check("mrst_valid", 32'(bus.insn_valid), 0);
        check("mrst_insn", bus.insn, 0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        next_cycle(); peek();
        check("mrst_c2_valid", 32'(bus.insn_valid), 1);
        check("mrst_c2_pc", bus.insn_pc, 32'h54);

        // Randomized traffic.
        pops_start = pops;
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            bus.insn_ready = ($urandom_range(3) != 0);
            r = int'($urandom_range(99));
            rst = (r == 0);
            bus.redirect_valid = (r >= 1 && r <= 3);
            bus.redirect_pc = ($urandom_range(3) == 0) ?
                              (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
        end
        next_cycle();
        rst                = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.insn_ready     = 1'b1;
        repeat (4) next_cycle();
        check("random_progress", 32'(pops - pops_start >= 1000), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
